// File: rtl/mining_pkg.sv
// Shared definitions for the nonce-search controller: default widths,
// the terminal nonce value and the FSM state encoding.
// Optional watchdog feature: MINING_WDOG_EN (see mining_ctrl).
package mining_pkg;

  localparam int NONCE_W_DEF  = 32;
  localparam int HASH_W_DEF   = 24;
  localparam int WDOG_CYC_DEF = 64;

  // Last nonce of the search space at the default width; the search never wraps past it.
  localparam logic [NONCE_W_DEF-1:0] NONCE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/mining_if.sv
// Bundle of host-side and datapath-side signals around the mining controller.
// Optional watchdog feature: MINING_WDOG_EN (affects only mining_ctrl).
//
// Handshake semantics (one place, applies to the whole bundle):
//   - start/abort are level requests sampled on every rising clk edge;
//     start is accepted only while the controller is in IDLE or DONE, abort
//     is accepted in every state and wins over start.
//   - hash_start is a 1-cycle launch pulse from the controller; the hash core
//     answers later with a 1-cycle hash_done pulse, hash_in valid in that
//     same cycle. The controller only consumes hash_done while it waits for
//     a result; a pulse arriving at any other time is dropped.
//   - nonce_start/target are consumed only in the cycle start is accepted.
interface mining_if
  import mining_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int HASH_W  = HASH_W_DEF
);

  logic               start;
  logic               abort;
  logic [NONCE_W-1:0] nonce_start;
  logic [HASH_W-1:0]  target;
  logic               hash_done;
  logic [HASH_W-1:0]  hash_in;
  logic               sel_concat;
  logic [NONCE_W-1:0] nonce_out;
  logic               hash_start;
  logic               busy;
  logic               found;
  logic               exhausted;
  logic [NONCE_W-1:0] found_nonce;

  // Controller side.
  modport master (
    input  start, abort, nonce_start, target, hash_done, hash_in,
    output sel_concat, nonce_out, hash_start, busy, found, exhausted, found_nonce
  );

  // Host / datapath side.
  modport slave (
    output start, abort, nonce_start, target, hash_done, hash_in,
    input  sel_concat, nonce_out, hash_start, busy, found, exhausted, found_nonce
  );

endinterface

// File: rtl/mining_nonce_counter.sv
// Current-nonce register: parallel load, increment, terminal-count flag.
// Optional watchdog feature: MINING_WDOG_EN (not used in this file).
module mining_nonce_counter
  import mining_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               inc,
  input  logic [NONCE_W-1:0] load_val,
  output logic [NONCE_W-1:0] value,
  output logic               at_max
);

  // Load wins over increment; increment wraps naturally but the FSM never
  // asks for it at the terminal value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= value + NONCE_W'(1);
    end
  end

  assign at_max = (value == {NONCE_W{1'b1}});

endmodule

// File: rtl/mining_ctrl.sv
// Nonce-search sequencer: loads a nonce into the concatenator, pulses the
// hash core, compares the result with the target and either advances to
// the next nonce or stops on a hit / exhausted nonce space.
// Optional feature macro: MINING_WDOG_EN enables a WAIT-state watchdog that
// ends the search (no hit, not exhausted) after WDOG_CYC cycles without hash_done.
module mining_ctrl
  import mining_pkg::*;
#(
  parameter int NONCE_W  = NONCE_W_DEF,
  parameter int HASH_W   = HASH_W_DEF,
  parameter int WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic   clk,
  input  logic   reset,
  mining_if.master bus,
  output state_t dbg_state
);

  state_t             state;
  logic [HASH_W-1:0]  target_q;
  logic [HASH_W-1:0]  hash_q;
  logic [NONCE_W-1:0] nonce;
  logic               at_max;
  logic               hit;
  logic               accept_start;
  logic               cnt_load;
  logic               cnt_inc;

  logic               sel_concat_q;
  logic               hash_start_q;
  logic               busy_q;
  logic               found_q;
  logic               exhausted_q;
  logic [NONCE_W-1:0] found_nonce_q;

`ifdef MINING_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] wdog_cnt;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYC;
`endif

  // Equality counts as a hit.
  assign hit          = (hash_q <= target_q);
  assign accept_start = bus.start && !bus.abort && ((state == S_IDLE) || (state == S_DONE));
  assign cnt_load     = accept_start;
  assign cnt_inc      = !bus.abort && (state == S_CHECK) && !hit && !at_max;

  mining_nonce_counter #(
    .NONCE_W (NONCE_W)
  ) u_nonce (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .inc      (cnt_inc),
    .load_val (bus.nonce_start),
    .value    (nonce),
    .at_max   (at_max)
  );

  // Search FSM with registered outputs; abort overrides every transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      target_q      <= '0;
      hash_q        <= '0;
      sel_concat_q  <= 1'b0;
      hash_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      found_nonce_q <= '0;
`ifdef MINING_WDOG_EN
      wdog_cnt      <= '0;
`endif
    end else if (bus.abort) begin
      state        <= S_IDLE;
      sel_concat_q <= 1'b0;
      hash_start_q <= 1'b0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            target_q     <= bus.target;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            sel_concat_q <= 1'b1;
            busy_q       <= 1'b1;
            state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          hash_start_q <= 1'b1;
          state        <= S_LAUNCH;
        end
        S_LAUNCH: begin
          hash_start_q <= 1'b0;
          state        <= S_WAIT;
`ifdef MINING_WDOG_EN
          wdog_cnt     <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.hash_done) begin
            hash_q <= bus.hash_in;
            state  <= S_CHECK;
          end
`ifdef MINING_WDOG_EN
          else if (wdog_cnt == WDOG_W'(WDOG_CYC - 1)) begin
            sel_concat_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            state        <= S_DONE;
          end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
          end
`endif
        end
        S_CHECK: begin
          if (hit) begin
            found_q       <= 1'b1;
            found_nonce_q <= nonce;
            sel_concat_q  <= 1'b0;
            busy_q        <= 1'b0;
            state         <= S_DONE;
          end else if (at_max) begin
            exhausted_q  <= 1'b1;
            sel_concat_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= S_DONE;
          end else begin
            state <= S_LOAD;
          end
        end
        default: begin
          state        <= S_IDLE;
          sel_concat_q <= 1'b0;
          hash_start_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel_concat  = sel_concat_q;
  assign bus.nonce_out   = nonce;
  assign bus.hash_start  = hash_start_q;
  assign bus.busy        = busy_q;
  assign bus.found       = found_q;
  assign bus.exhausted   = exhausted_q;
  assign bus.found_nonce = found_nonce_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_mining_ctrl.sv
// Directed + randomized bench for mining_ctrl with a behavioural hash-core
// responder and a search-outcome reference model.
// Watchdog scenario is compiled in when MINING_WDOG_EN is defined.
module tb_mining_ctrl;
  import mining_pkg::*;

  localparam int NW = 32;
  localparam int HW = 24;
  localparam logic [HW-1:0] HASH_ALL = '1;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  always #5 clk = ~clk;

  mining_if #(.NONCE_W(NW), .HASH_W(HW)) bus ();

  mining_ctrl #(.NONCE_W(NW), .HASH_W(HW), .WDOG_CYC(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- hash core responder ----------------
  logic [HW-1:0] hash_seq[$];   // results returned in order, one per launch
  int            seq_gen = 0;   // bumped by the stimulus when hash_seq is replaced
  int            hash_lat = 0;  // extra cycles beyond the first WAIT cycle
  logic          core_en = 1'b1;
  int            pulse_log[$];  // cycle stamp of every observed hash_start

  logic          rsp_done = 1'b0;
  logic [HW-1:0] rsp_val = '0;
  int            rsp_cnt = 0;
  int            rsp_idx = 0;
  int            seen_gen = 0;

  assign bus.hash_done = rsp_done;
  assign bus.hash_in   = rsp_val;

  always @(negedge clk) begin
    rsp_done = 1'b0;
    if (seq_gen != seen_gen) begin
      seen_gen = seq_gen;
      rsp_idx  = 0;
    end
    if (reset) begin
      rsp_cnt = 0;
    end else begin
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) rsp_done = 1'b1;
      end
      if (bus.hash_start && core_en) begin
        pulse_log.push_back(cyc);
        rsp_val = (rsp_idx < hash_seq.size()) ? hash_seq[rsp_idx] : HASH_ALL;
        rsp_idx++;
        rsp_cnt = hash_lat + 1;
      end
    end
  end

  // ---------------- driver / check helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the nonce space from ns using the queued results.
  // A result <= target is a hit; a miss on the all-ones nonce ends the search.
  task automatic run_search(input logic [NW-1:0] ns, input logic [HW-1:0] tgt,
                            input int lat, input bit poke_start, input string tag);
    logic [HW-1:0] model_q[$];
    logic [HW-1:0] h;
    logic [NW-1:0] n;
    logic          exp_found;
    logic          exp_exh;
    int            exp_pulses;
    int            base;
    int            waited;

    model_q    = hash_seq;
    n          = ns;
    exp_found  = 1'b0;
    exp_exh    = 1'b0;
    exp_pulses = 0;
    forever begin
      h = (exp_pulses < model_q.size()) ? model_q[exp_pulses] : HASH_ALL;
      exp_pulses++;
      if (h <= tgt) begin
        exp_found = 1'b1;
        break;
      end
      if (n == NONCE_MAX) begin
        exp_exh = 1'b1;
        break;
      end
      n = n + 1;
    end

    seq_gen++;
    hash_lat        = lat;
    base            = pulse_log.size();
    bus.nonce_start = ns;
    bus.target      = tgt;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, ".load_state"}, 64'(dbg_state), 64'(S_LOAD));
    chk({tag, ".load_sel"}, 64'(bus.sel_concat), 64'd1);
    chk({tag, ".load_nonce"}, 64'(bus.nonce_out), 64'(ns));

    waited = 0;
    while (bus.busy && waited < 3000) begin
      if (poke_start && waited == 3) begin
        bus.start       = 1'b1;
        bus.nonce_start = ns ^ 32'h00F0_F00F;
        bus.target      = '1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      waited++;
    end
    bus.start = 1'b0;

    chk({tag, ".ended"}, 64'(bus.busy), 64'd0);
    chk({tag, ".state"}, 64'(dbg_state), 64'(S_DONE));
    chk({tag, ".sel"}, 64'(bus.sel_concat), 64'd0);
    chk({tag, ".found"}, 64'(bus.found), 64'(exp_found));
    chk({tag, ".exhausted"}, 64'(bus.exhausted), 64'(exp_exh));
    chk({tag, ".last_nonce"}, 64'(bus.nonce_out), 64'(n));
    if (exp_found) chk({tag, ".found_nonce"}, 64'(bus.found_nonce), 64'(n));
    chk({tag, ".pulses"}, 64'(pulse_log.size() - base), 64'(exp_pulses));
    for (int i = base + 1; i < pulse_log.size(); i++)
      chk({tag, ".spacing"}, 64'(pulse_log[i] - pulse_log[i-1]), 64'(4 + lat));
    repeat (lat + 3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [HW-1:0] tgt;
    logic [NW-1:0] ns;
    int            k;
    int            base;
    int            n;

    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.nonce_start = '0;
    bus.target      = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst.state", 64'(dbg_state), 64'(S_IDLE));
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.sel", 64'(bus.sel_concat), 64'd0);
    chk("rst.hash_start", 64'(bus.hash_start), 64'd0);
    chk("rst.found", 64'(bus.found), 64'd0);
    chk("rst.exhausted", 64'(bus.exhausted), 64'd0);
    chk("rst.nonce_out", 64'(bus.nonce_out), 64'd0);
    chk("rst.found_nonce", 64'(bus.found_nonce), 64'd0);

    // Hit on the first nonce
    hash_seq = '{24'h0000FF};
    run_search(32'd5, 24'h000100, 3, 1'b0, "hit_first");

    // Two misses then a hit; a start pulse mid-search must be ignored
    hash_seq = '{24'hFFFFFF, 24'hFFFFFF, 24'h000010};
    run_search(32'd0, 24'h000100, 2, 1'b1, "miss_hit");

    // Exhaustion at the top of the nonce space
    hash_seq = '{24'hFFFFFF, 24'hFFFFFF};
    run_search(32'hFFFF_FFFE, 24'h000010, 0, 1'b0, "exhaust");

    // Equality boundary
    hash_seq = '{24'h001235, 24'h001234};
    run_search(32'h0000_0100, 24'h001234, 1, 1'b0, "equal");

    // Randomized searches
    for (int t = 0; t < 12; t++) begin
      tgt = HW'($urandom_range(0, 32'h00FF_FFF0));
      k   = $urandom_range(0, 4);
      hash_seq.delete();
      for (int i = 0; i < k; i++)
        hash_seq.push_back(HW'($urandom_range(32'(tgt) + 1, 32'h00FF_FFFF)));
      if ($urandom_range(0, 3) == 0) hash_seq.push_back(tgt);
      else hash_seq.push_back(HW'($urandom_range(0, 32'(tgt))));
      if ($urandom_range(0, 2) == 0) ns = NONCE_MAX - NW'($urandom_range(0, 3));
      else ns = $urandom;
      run_search(ns, tgt, $urandom_range(0, 5), 1'b0, $sformatf("rand%0d", t));
    end

    // Abort while waiting for the hash; the late result must be dropped
    seq_gen++;
    hash_seq        = '{24'h000000};
    hash_lat        = 6;
    base            = pulse_log.size();
    bus.nonce_start = 32'h0000_0042;
    bus.target      = '1;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("abort.pre_state", 64'(dbg_state), 64'(S_WAIT));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort.state", 64'(dbg_state), 64'(S_IDLE));
    chk("abort.sel", 64'(bus.sel_concat), 64'd0);
    chk("abort.busy", 64'(bus.busy), 64'd0);
    repeat (10) tick();
    chk("abort.late_state", 64'(dbg_state), 64'(S_IDLE));
    chk("abort.late_found", 64'(bus.found), 64'd0);
    chk("abort.pulses", 64'(pulse_log.size() - base), 64'd1);

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort.state", 64'(dbg_state), 64'(S_IDLE));
    chk("start_abort.busy", 64'(bus.busy), 64'd0);
    tick();
    chk("start_abort.state2", 64'(dbg_state), 64'(S_IDLE));

    // Asynchronous reset during LAUNCH
    seq_gen++;
    hash_seq  = '{24'h000000};
    hash_lat  = 2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("areset.launch_pulse", 64'(bus.hash_start), 64'd1);
    reset = 1'b1;
    #1;
    chk("areset.hash_start", 64'(bus.hash_start), 64'd0);
    chk("areset.state", 64'(dbg_state), 64'(S_IDLE));
    chk("areset.busy", 64'(bus.busy), 64'd0);
    chk("areset.nonce", 64'(bus.nonce_out), 64'd0);
    #2;
    reset = 1'b0;
    repeat (6) tick();

    // No hash_done at all
    core_en         = 1'b0;
    bus.nonce_start = 32'h0000_0007;
    bus.target      = '1;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
`ifdef MINING_WDOG_EN
    n = 0;
    while (dbg_state == S_WAIT && n < 100) begin
      n++;
      tick();
    end
    chk("wdog.wait_cycles", 64'(n), 64'd8);
    chk("wdog.state", 64'(dbg_state), 64'(S_DONE));
    chk("wdog.found", 64'(bus.found), 64'd0);
    chk("wdog.exhausted", 64'(bus.exhausted), 64'd0);
    chk("wdog.busy", 64'(bus.busy), 64'd0);
    chk("wdog.sel", 64'(bus.sel_concat), 64'd0);
`else
    n = 0;
    repeat (100) tick();
    chk("hold.state", 64'(dbg_state), 64'(S_WAIT));
    chk("hold.busy", 64'(bus.busy), 64'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("hold.abort_state", 64'(dbg_state), 64'(S_IDLE));
`endif
    core_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
